// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: occupancy encoding and
// default payload/counter widths.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 16;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; used for the
// stall and flush statistics of pipe_stage_reg.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: assign the hold value first so every path writes count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst_p) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshakes, optional skid entry,
// flush/stall control and saturating stall/flush statistics.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SKID  = 1,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             has_room;
  logic             accept;
  logic             pop;

  // With a skid entry, in_ready depends only on registered occupancy, which
  // breaks the out_ready -> in_ready combinational path.
  always_comb begin
    if (SKID != 0) has_room = (occ_q < OCC_FULL);
    else           has_room = (occ_q == OCC_EMPTY) || out_ready;
  end

  assign in_ready  = !rst_p && !stall && has_room;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = out_valid ? main_q : '0;
  assign occupancy = occ_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !stall;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else if (!stall) begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_d = in_data;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (pop) begin
            occ_d = OCC_EMPTY;
          end else if (accept) begin
            skid_d = in_data;
            occ_d  = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            main_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: payload storage is reset too, so a freshly reset stage holds no stale data.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
    end
  end

  if (SKID != 0) begin : g_skid
    always_ff @(posedge clk) begin
      if (rst_p) skid_q <= '0;
      else       skid_q <= skid_d;
    end
  end else begin : g_no_skid
    assign skid_q = '0;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_p (rst_p),
    .inc   (stall && out_valid && !flush),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_p (rst_p),
    .inc   (flush && out_valid),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 16, payload bits carried per stage entry.
REQ-002 Parameter SKID, default 1; 0 = single-entry register, 1 = two-entry (main + skid) register.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_p  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  kill all held entries (bubble insert).
REQ-007 stall  input  1  freeze stage contents and both handshakes.
REQ-008 in_valid  input  1  upstream entry offered.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_data  input  WIDTH  upstream payload.
REQ-011 out_valid  output  1  head entry present.
REQ-012 out_ready  input  1  downstream accepts head.
REQ-013 out_data  output  WIDTH  head payload.
REQ-014 occupancy  output  2  entries held, 0..2.
REQ-015 stall_cnt  output  CNT_W  cycles spent stalled while holding a valid entry.
REQ-016 flush_cnt  output  CNT_W  flushes that discarded at least one entry.

Function
REQ-017 Per-cycle priority SHALL be rst_p > flush > stall > normal operation.
REQ-018 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready && !stall.
REQ-019 Entries SHALL leave in acceptance order; no reordering, no duplication, no loss except by flush/reset.
REQ-020 SKID=1: in_ready SHALL equal !stall && (occupancy < 2), derived from registered state only (no combinational out_ready->in_ready path).
REQ-021 SKID=0: in_ready SHALL equal !stall && (!out_valid || out_ready); occupancy never exceeds 1.
REQ-022 Accept into an empty stage SHALL make the entry visible at out_data/out_valid on the next cycle (latency 1).
REQ-023 Accept and pop in the same cycle SHALL leave occupancy unchanged; at occupancy 1 the new entry becomes head next cycle.
REQ-024 SKID=1, occupancy 1, accept without pop: entry SHALL go to skid; after the head pops, skid SHALL become head the next cycle.
REQ-025 Stall: all storage, occupancy and out_valid SHALL hold; in_ready SHALL be 0; out_ready SHALL be ignored.
REQ-026 Flush: next cycle occupancy SHALL be 0 and out_valid 0; any accept or pop in the flush cycle SHALL be discarded/void; flush overrides stall.
REQ-027 out_data SHALL be all-zero whenever out_valid is 0, so an invalid entry decodes as a no-op control word.
REQ-028 stall_cnt SHALL increment by 1 on each cycle with stall && out_valid && !flush, saturating at 2^CNT_W-1.
REQ-029 flush_cnt SHALL increment by 1 on each cycle with flush && occupancy != 0, saturating at 2^CNT_W-1.
REQ-030 Counters SHALL clear only on reset.

Reset
REQ-031 On rst_p sampled high: occupancy 0, out_valid 0, out_data 0, both storage entries 0, stall_cnt 0, flush_cnt 0.
REQ-032 in_ready SHALL be 0 during a reset cycle and SHALL equal 1 on the first cycle after reset if stall is 0.
REQ-033 Reset mid-transfer SHALL discard all held entries and any same-cycle handshake.

Structure
REQ-034 Shared package pipe_pkg SHALL hold the occupancy encoding constants (OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2) and the default WIDTH/CNT_W values.
REQ-035 One sub-module, sat_counter (parameter CNT_W; inputs clk, rst_p, inc; output count), SHALL implement both counters.
REQ-036 SKID=0 SHALL synthesise no skid storage.

Verification
REQ-037 Reset, then push 0x00A1,0x00A2,0x00A3 with out_ready=1 -> out_data 0x00A1,0x00A2,0x00A3 on consecutive cycles starting one cycle after first accept; occupancy stays 1.
REQ-038 SKID=1, out_ready=0, push 0x0011,0x0022,0x0033 -> two accepted, in_ready=0 on third, occupancy=2; release out_ready -> 0x0011 then 0x0022, then 0x0033 accepted.
REQ-039 Occupancy 2, assert stall 3 cycles with out_ready=1 -> contents held, in_ready=0, stall_cnt=3; deassert -> pops resume in order.
REQ-040 Occupancy 2, flush together with stall and in_valid=1 (0x0044) -> next cycle occupancy 0, out_valid 0, out_data 0x0000, flush_cnt=1; 0x0044 never appears.
REQ-041 CNT_W=2, hold stall with valid entry 5 cycles -> stall_cnt reads 3 and stays 3; flush on empty stage -> flush_cnt unchanged.
REQ-042 SKID=0, occupancy 1, out_ready=1, in_valid=1 (0x0055) -> same-cycle pop and accept, 0x0055 at head next cycle, occupancy 1.
